// File: rtl/instr_mem_pipe.sv
// ---------------------------------------------------------------------------
// instr_mem_pipe
//
// Purpose:
//   Synchronous-read instruction memory for the pipelined RISC-V core. It sits
//   between the PC/fetch stage and the IF/ID register. Fetches use a
//   valid/ready handshake and have a fixed 1-cycle latency. The response is
//   held in a one-entry output register that can stall under back-pressure.
//   A program-load write port lets the boot loader or a testbench fill the
//   array. Misaligned or out-of-range PCs return a NOP and raise a fault flag
//   instead of aliasing into the array.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset (memory contents kept)
//   req_valid  in   1   fetch request valid
//   req_ready  out  1   a fetch can be accepted this cycle (combinational)
//   A          in   N   fetch byte address (PC)
//   rsp_valid  out  1   RD/fault hold a fetch result
//   rsp_ready  in   1   consumer takes the result this cycle
//   RD         out  N   fetched instruction word (registered)
//   fault      out  1   result came from a misaligned or out-of-range PC
//   prog_we    in   1   program-load write strobe (wins over fetches)
//   prog_addr  in   AW  program-load word index
//   prog_data  in   N   program-load data
// ---------------------------------------------------------------------------
module instr_mem_pipe #(
  parameter int             N         = 32,
  parameter int             MEM_SIZE  = 1024,
  parameter                 INIT_FILE = "",
  parameter logic [N-1:0]   NOP_INSTR = 32'h00000013,
  localparam int            AW        = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  A,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  RD,
  output logic          fault,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [N-1:0]  prog_data
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

  rsp_state_t state;
  rsp_state_t state_next;

  logic [N-1:0]  mem [MEM_SIZE];

  logic [AW-1:0] idx;
  logic [N-1:0]  high_bits;
  logic          misaligned;
  logic          out_of_range;
  logic          bad_addr;
  logic          accept;
  logic          load_rsp;
  logic          clear_rsp;

  // Address decode. Anything above the array faults rather than wrapping, so
  // the upper bits are checked as a whole after shifting out the in-range part.
  assign idx          = A[AW+1:2];
  assign high_bits    = A >> (AW + 2);
  assign misaligned   = |A[1:0];
  assign out_of_range = |high_bits;
  assign bad_addr     = misaligned | out_of_range;

  // A new fetch is only taken when the output slot is free or being emptied
  // this same cycle, which is what gives full 1-fetch/cycle throughput.
  assign rsp_valid = (state == FULL);
  assign req_ready = !rst && !prog_we && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and response-register controls. load_rsp captures a new fetch
  // result; clear_rsp returns the outputs to the idle NOP when the consumer
  // drains the slot and nothing replaces it.
  always_comb begin
    state_next = state;
    load_rsp   = 1'b0;
    clear_rsp  = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = FULL;
          load_rsp   = 1'b1;
        end
      end
      FULL: begin
        if (accept) begin
          state_next = FULL;
          load_rsp   = 1'b1;
        end else if (rsp_ready) begin
          state_next = EMPTY;
          clear_rsp  = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
        clear_rsp  = 1'b1;
      end
    endcase
  end

  // Program-load port. Reset blocks writes; fetches are locked out in a write
  // cycle, so a read never sees the same word being written.
  always_ff @(posedge clk) begin
    if (!rst && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Response register. A faulting fetch still produces a valid response so the
  // pipeline can carry the fault forward, but with a harmless NOP as payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      RD    <= NOP_INSTR;
      fault <= 1'b0;
    end else if (load_rsp) begin
      if (bad_addr) begin
        RD    <= NOP_INSTR;
        fault <= 1'b1;
      end else begin
        RD    <= mem[idx];
        fault <= 1'b0;
      end
    end else if (clear_rsp) begin
      RD    <= NOP_INSTR;
      fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_pipe
//
// Directed and randomised checks of the instruction memory: reset state,
// back-to-back fetches, back-pressure stalls, address faults, program-load
// priority, reset while stalled, and a random valid/ready run against a
// small behavioural model of the one-entry response slot.
// ---------------------------------------------------------------------------
module tb_instr_mem_pipe;

  localparam int          N        = 32;
  localparam int          MEM_SIZE = 1024;
  localparam int          AW       = $clog2(MEM_SIZE);
  localparam logic [31:0] NOP      = 32'h00000013;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [N-1:0]  A;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  RD;
  logic          fault;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [N-1:0]  prog_data;

  int vectors;
  int miscompares;

  logic [31:0] tb_mem [16];

  instr_mem_pipe #(
    .N        (N),
    .MEM_SIZE (MEM_SIZE),
    .INIT_FILE(""),
    .NOP_INSTR(NOP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .A        (A),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .RD       (RD),
    .fault    (fault),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h00500293;
      1:       return 32'h00400313;
      2:       return 32'h0062E3B3;
      3:       return 32'h0062F433;
      default: return 32'h10000000 + 32'(i) * 32'h00000111;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1; A = 32'h0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    tick();
    tick();
    vectors++;
    if ({rsp_valid, fault, RD} !== {1'b0, 1'b0, NOP}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got v=%b f=%b rd=%h, expected v=0 f=0 rd=%h", rsp_valid, fault, RD, NOP);
    end
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_req_ready: got %b, expected 0", req_ready);
    end
    rst = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tb_mem[i] = init_word(i);
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = tb_mem[i]; req_valid = 1'b1;
      #1;
      if (i == 0) begin
        vectors++;
        if (req_ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL prog_blocks_ready: got %b, expected 0", req_ready);
        end
      end
      tick();
    end
    prog_we = 1'b0; req_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; A = 32'(i * 4);
      tick();
      vectors++;
      if ({rsp_valid, fault, RD} !== {1'b1, 1'b0, init_word(i)}) begin
        miscompares++;
        $display("[TB] FAIL b2b_word%0d: got v=%b f=%b rd=%h, expected v=1 f=0 rd=%h", i, rsp_valid, fault, RD, init_word(i));
      end
    end
    req_valid = 1'b0;
    tick();
    vectors++;
    if ({rsp_valid, fault, RD} !== {1'b0, 1'b0, NOP}) begin
      miscompares++;
      $display("[TB] FAIL b2b_drain: got v=%b f=%b rd=%h, expected v=0 f=0 rd=%h", rsp_valid, fault, RD, NOP);
    end
  endtask

  task automatic test_stall();
    req_valid = 1'b1; A = 32'h4; rsp_ready = 1'b0;
    tick();
    A = 32'h8;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({req_ready, rsp_valid, fault, RD} !== {1'b0, 1'b1, 1'b0, 32'h00400313}) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got rdy=%b v=%b f=%b rd=%h, expected rdy=0 v=1 f=0 rd=00400313", c, req_ready, rsp_valid, fault, RD);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_release_ready: got %b, expected 1", req_ready);
    end
    tick();
    vectors++;
    if ({rsp_valid, fault, RD} !== {1'b1, 1'b0, 32'h0062E3B3}) begin
      miscompares++;
      $display("[TB] FAIL stall_next: got v=%b f=%b rd=%h, expected v=1 f=0 rd=0062e3b3", rsp_valid, fault, RD);
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_fault();
    logic [31:0] addrs [4];
    logic [31:0] exp_rd [4];
    logic        exp_f [4];
    addrs[0] = 32'h2;    exp_rd[0] = NOP;          exp_f[0] = 1'b1;
    addrs[1] = 32'h1000; exp_rd[1] = NOP;          exp_f[1] = 1'b1;
    addrs[2] = 32'hFFC;  exp_rd[2] = 32'h0BADF00D; exp_f[2] = 1'b0;
    addrs[3] = 32'h8000_0000; exp_rd[3] = NOP;     exp_f[3] = 1'b1;
    prog_we = 1'b1; prog_addr = AW'(1023); prog_data = 32'h0BADF00D;
    tick();
    prog_we = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; A = addrs[i];
      tick();
      vectors++;
      if ({rsp_valid, fault, RD} !== {1'b1, exp_f[i], exp_rd[i]}) begin
        miscompares++;
        $display("[TB] FAIL fault_addr_%h: got v=%b f=%b rd=%h, expected v=1 f=%b rd=%h", addrs[i], rsp_valid, fault, RD, exp_f[i], exp_rd[i]);
      end
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_prog_load();
    rsp_ready = 1'b1;
    prog_we = 1'b1; prog_addr = AW'(5); prog_data = 32'hDEADBEEF;
    req_valid = 1'b1; A = 32'h14;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL prog_priority_ready: got %b, expected 0", req_ready);
    end
    tick();
    tb_mem[5] = 32'hDEADBEEF;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL prog_no_accept: got v=%b, expected 0", rsp_valid);
    end
    prog_we = 1'b0;
    tick();
    vectors++;
    if ({rsp_valid, fault, RD} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      miscompares++;
      $display("[TB] FAIL prog_readback: got v=%b f=%b rd=%h, expected v=1 f=0 rd=deadbeef", rsp_valid, fault, RD);
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    req_valid = 1'b1; A = 32'hC; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    vectors++;
    if ({rsp_valid, RD} !== {1'b1, 32'h0062F433}) begin
      miscompares++;
      $display("[TB] FAIL rst_stall_setup: got v=%b rd=%h, expected v=1 rd=0062f433", rsp_valid, RD);
    end
    rst = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = 32'hFFFFFFFF;
    tick();
    rst = 1'b0; prog_we = 1'b0;
    vectors++;
    if ({rsp_valid, fault, RD} !== {1'b0, 1'b0, NOP}) begin
      miscompares++;
      $display("[TB] FAIL rst_stall_clear: got v=%b f=%b rd=%h, expected v=0 f=0 rd=%h", rsp_valid, fault, RD, NOP);
    end
    req_valid = 1'b1; A = 32'h0; rsp_ready = 1'b1;
    tick();
    vectors++;
    if ({rsp_valid, fault, RD} !== {1'b1, 1'b0, 32'h00500293}) begin
      miscompares++;
      $display("[TB] FAIL rst_retained: got v=%b f=%b rd=%h, expected v=1 f=0 rd=00500293", rsp_valid, fault, RD);
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic        m_valid;
    logic [31:0] m_rd;
    logic        m_fault;
    logic        exp_ready;
    logic        bad;
    int          r;
    m_valid = 1'b0; m_rd = NOP; m_fault = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 19);
      case (r)
        16:      A = 32'h2;
        17:      A = 32'h1000;
        18:      A = 32'hFFFFFFFC;
        19:      A = 32'h13;
        default: A = 32'(r * 4);
      endcase
      #1;
      exp_ready = !m_valid || rsp_ready;
      vectors++;
      if (req_ready !== exp_ready) begin
        miscompares++;
        $display("[TB] FAIL rand_ready c=%0d: got %b, expected %b", c, req_ready, exp_ready);
      end
      if (req_valid && exp_ready) begin
        bad     = (A[1:0] != 2'b00) || (A >= 32'(4 * MEM_SIZE));
        m_valid = 1'b1;
        m_fault = bad;
        m_rd    = bad ? NOP : tb_mem[A[5:2]];
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0; m_rd = NOP; m_fault = 1'b0;
      end
      tick();
      vectors++;
      if ({rsp_valid, fault, RD} !== {m_valid, m_fault, m_rd}) begin
        miscompares++;
        $display("[TB] FAIL rand_rsp c=%0d: got v=%b f=%b rd=%h, expected v=%b f=%b rd=%h", c, rsp_valid, fault, RD, m_valid, m_fault, m_rd);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; A = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_fault();
    test_prog_load();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
